// File: rtl/lab_f_to_cie_pkg.sv
// rtl/lab_f_to_cie_pkg.sv - shared constants, field types and width helper for the f-space to CIE back end
// Constants: L = K_L*fy - L_OFS, a = K_A*(fx-fy), b = K_B*(fy-fz).
// Field limits: L in [0,L_MAX], a in [-A_MAX,A_MAX], b in [-B_MAX,B_MAX].
package lab_f_to_cie_pkg;

    localparam int K_L   = 116;
    localparam int K_A   = 500;
    localparam int K_B   = 200;
    localparam int L_OFS = 16;
    localparam int L_MAX = 100;
    localparam int A_MAX = 511;
    localparam int B_MAX = 255;

    localparam int CIE_L_W = 7;
    localparam int CIE_A_W = 10;
    localparam int CIE_B_W = 9;

    typedef logic [CIE_L_W-1:0] cie_l_t;
    typedef logic [CIE_A_W-1:0] cie_a_t;
    typedef logic [CIE_B_W-1:0] cie_b_t;

    // Width of an unsigned dsize-bit value times constant k (k >= 2).
    function automatic int prod_width(input int dsize, input int k);
        return dsize + $clog2(k);
    endfunction

endpackage

// File: rtl/lab_f_to_cie_if.sv
// rtl/lab_f_to_cie_if.sv - valid/ready stream bundle between f(t) stage, LAB converter and LAB output port
// Input side : in_valid, in_ready, fx, fy, fz (unsigned Q0.DSIZE).
// Output side: out_valid, out_ready, CIE_L, CIE_A, CIE_B, sign_a, sign_b, sat (LAB_SAT_FLAG_EN only).
// slave  modport: the converter. master modport: the surrounding logic driving it.
interface lab_f_to_cie_if #(
    parameter int DSIZE = 16
);
    import lab_f_to_cie_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [DSIZE-1:0] fx;
    logic [DSIZE-1:0] fy;
    logic [DSIZE-1:0] fz;
    logic             out_valid;
    logic             out_ready;
    cie_l_t           CIE_L;
    cie_a_t           CIE_A;
    cie_b_t           CIE_B;
    logic             sign_a;
    logic             sign_b;
`ifdef LAB_SAT_FLAG_EN
    logic             sat;

    modport slave (
        input  in_valid, fx, fy, fz, out_ready,
        output in_ready, out_valid, CIE_L, CIE_A, CIE_B, sign_a, sign_b, sat
    );

    modport master (
        output in_valid, fx, fy, fz, out_ready,
        input  in_ready, out_valid, CIE_L, CIE_A, CIE_B, sign_a, sign_b, sat
    );
`else
    modport slave (
        input  in_valid, fx, fy, fz, out_ready,
        output in_ready, out_valid, CIE_L, CIE_A, CIE_B, sign_a, sign_b
    );

    modport master (
        output in_valid, fx, fy, fz, out_ready,
        input  in_ready, out_valid, CIE_L, CIE_A, CIE_B, sign_a, sign_b
    );
`endif

endinterface

// File: rtl/lab_round_clamp.sv
// rtl/lab_round_clamp.sv - round, offset, sign-apply and clamp for one CIE field
// Parameters: DSIZE fraction bits of i_p, PW width of i_p, OW output width,
//             OFS subtracted from the rounded magnitude, LO/HI clamp limits.
// Ports: i_p     unsigned product magnitude (Q.DSIZE)
//        i_neg   apply negative sign after rounding
//        o_val   clamped field, two's complement, OW bits
//        o_clamped  field hit a limit (LAB_SAT_FLAG_EN only)
// Purely combinational; the caller registers the result.
module lab_round_clamp #(
    parameter int DSIZE = 16,
    parameter int PW    = 23,
    parameter int OW    = 7,
    parameter int OFS   = 0,
    parameter int LO    = 0,
    parameter int HI    = 100
) (
    input  logic [PW-1:0] i_p,
    input  logic          i_neg,
    output logic [OW-1:0] o_val
`ifdef LAB_SAT_FLAG_EN
    ,
    output logic          o_clamped
`endif
);

    logic [PW:0]        w_sum;
    logic signed [31:0] w_mag;
    logic signed [31:0] w_v;
    logic signed [31:0] w_c;
    logic               w_lo;
    logic               w_hi;

    // Half-up rounding on the magnitude; the extra top bit absorbs the carry.
    assign w_sum = {1'b0, i_p} + (PW+1)'(1 << (DSIZE-1));
    assign w_mag = $signed(32'(w_sum >> DSIZE));

    // Sign goes on after rounding so +x and -x round to the same magnitude;
    // a negated zero is plain 0 in two's complement.
    assign w_v = i_neg ? (32'sd0 - w_mag) : (w_mag - OFS);

    always_comb begin
        w_lo = (w_v < LO);
        w_hi = (w_v > HI);
        w_c  = w_v;
        if (w_hi) begin
            w_c = HI;
        end else if (w_lo) begin
            w_c = LO;
        end
    end

    assign o_val = OW'(w_c);

`ifdef LAB_SAT_FLAG_EN
    assign o_clamped = w_lo | w_hi;
`endif

endmodule

// File: rtl/lab_f_to_cie.sv
// rtl/lab_f_to_cie.sv - 3-stage f-space (fx,fy,fz) to CIE L/a/b converter with valid/ready
// Ports: clock  rising-edge clock
//        rst_n  asynchronous active-low reset (release synchronous to clock)
//        bus    lab_f_to_cie_if.slave: fx/fy/fz input stream, CIE_L/CIE_A/CIE_B/sign_a/sign_b output
// Optional feature macro: LAB_SAT_FLAG_EN adds bus.sat, set when any field of the beat was clamped.
// Stages: S1 difference/magnitude, S2 constant products, S3 round/clamp register.
module lab_f_to_cie
    import lab_f_to_cie_pkg::*;
#(
    parameter int DSIZE = 16
) (
    input  logic          clock,
    input  logic          rst_n,
    lab_f_to_cie_if.slave bus
);

    localparam int PL_W = prod_width(DSIZE, K_L);
    localparam int PA_W = prod_width(DSIZE, K_A);
    localparam int PB_W = prod_width(DSIZE, K_B);

    // Whole pipe advances together; a stalled output freezes every stage,
    // so bubbles stay where they are.
    logic w_en;

    // S1
    logic             r_v1;
    logic [DSIZE-1:0] r_fy1;
    logic             r_sa1;
    logic [DSIZE-1:0] r_ma1;
    logic             r_sb1;
    logic [DSIZE-1:0] r_mb1;
    // S2
    logic             r_v2;
    logic [PL_W-1:0]  r_pl2;
    logic [PA_W-1:0]  r_pa2;
    logic             r_sa2;
    logic [PB_W-1:0]  r_pb2;
    logic             r_sb2;
    // S3
    logic             r_v3;
    cie_l_t           r_l3;
    cie_a_t           r_a3;
    cie_b_t           r_b3;

    logic [DSIZE:0]   w_da;
    logic [DSIZE:0]   w_db;
    logic [DSIZE-1:0] w_ma;
    logic [DSIZE-1:0] w_mb;
    cie_l_t           w_l;
    cie_a_t           w_a;
    cie_b_t           w_b;

    assign w_en         = !r_v3 | bus.out_ready;
    assign bus.in_ready = w_en;

    // (DSIZE+1)-bit signed differences; |d| always fits DSIZE bits.
    assign w_da = {1'b0, bus.fx} - {1'b0, bus.fy};
    assign w_db = {1'b0, bus.fy} - {1'b0, bus.fz};
    assign w_ma = DSIZE'(w_da[DSIZE] ? -w_da : w_da);
    assign w_mb = DSIZE'(w_db[DSIZE] ? -w_db : w_db);

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_v1  <= 1'b0;
            r_fy1 <= '0;
            r_sa1 <= 1'b0;
            r_ma1 <= '0;
            r_sb1 <= 1'b0;
            r_mb1 <= '0;
        end else if (w_en) begin
            r_v1  <= bus.in_valid;
            r_fy1 <= bus.fy;
            r_sa1 <= w_da[DSIZE];
            r_ma1 <= w_ma;
            r_sb1 <= w_db[DSIZE];
            r_mb1 <= w_mb;
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_v2  <= 1'b0;
            r_pl2 <= '0;
            r_pa2 <= '0;
            r_sa2 <= 1'b0;
            r_pb2 <= '0;
            r_sb2 <= 1'b0;
        end else if (w_en) begin
            r_v2  <= r_v1;
            r_pl2 <= PL_W'(r_fy1) * PL_W'(K_L);
            r_pa2 <= PA_W'(r_ma1) * PA_W'(K_A);
            r_sa2 <= r_sa1;
            r_pb2 <= PB_W'(r_mb1) * PB_W'(K_B);
            r_sb2 <= r_sb1;
        end
    end

`ifdef LAB_SAT_FLAG_EN
    logic w_clamp_l;
    logic w_clamp_a;
    logic w_clamp_b;
    logic r_sat3;
`endif

    lab_round_clamp #(
        .DSIZE (DSIZE),
        .PW    (PL_W),
        .OW    (CIE_L_W),
        .OFS   (L_OFS),
        .LO    (0),
        .HI    (L_MAX)
    ) u_rc_l (
        .i_p       (r_pl2),
        .i_neg     (1'b0),
        .o_val     (w_l)
`ifdef LAB_SAT_FLAG_EN
        ,
        .o_clamped (w_clamp_l)
`endif
    );

    lab_round_clamp #(
        .DSIZE (DSIZE),
        .PW    (PA_W),
        .OW    (CIE_A_W),
        .OFS   (0),
        .LO    (-A_MAX),
        .HI    (A_MAX)
    ) u_rc_a (
        .i_p       (r_pa2),
        .i_neg     (r_sa2),
        .o_val     (w_a)
`ifdef LAB_SAT_FLAG_EN
        ,
        .o_clamped (w_clamp_a)
`endif
    );

    lab_round_clamp #(
        .DSIZE (DSIZE),
        .PW    (PB_W),
        .OW    (CIE_B_W),
        .OFS   (0),
        .LO    (-B_MAX),
        .HI    (B_MAX)
    ) u_rc_b (
        .i_p       (r_pb2),
        .i_neg     (r_sb2),
        .o_val     (w_b)
`ifdef LAB_SAT_FLAG_EN
        ,
        .o_clamped (w_clamp_b)
`endif
    );

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_v3 <= 1'b0;
            r_l3 <= '0;
            r_a3 <= '0;
            r_b3 <= '0;
        end else if (w_en) begin
            r_v3 <= r_v2;
            r_l3 <= w_l;
            r_a3 <= w_a;
            r_b3 <= w_b;
        end
    end

`ifdef LAB_SAT_FLAG_EN
    // Travels with the S3 data so it stays aligned and holds under stall.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_sat3 <= 1'b0;
        end else if (w_en) begin
            r_sat3 <= w_clamp_l | w_clamp_a | w_clamp_b;
        end
    end

    assign bus.sat = r_sat3;
`endif

    assign bus.out_valid = r_v3;
    assign bus.CIE_L     = r_l3;
    assign bus.CIE_A     = r_a3;
    assign bus.CIE_B     = r_b3;
    assign bus.sign_a    = r_a3[CIE_A_W-1];
    assign bus.sign_b    = r_b3[CIE_B_W-1];

endmodule

// File: tb/tb_lab_f_to_cie.sv
// tb/tb_lab_f_to_cie.sv - directed table-driven bench for lab_f_to_cie
module tb_lab_f_to_cie;
    import lab_f_to_cie_pkg::*;

    localparam int DSIZE = 16;

    logic clock = 1'b0;
    logic rst_n = 1'b0;

    lab_f_to_cie_if #(.DSIZE(DSIZE)) bus ();

    lab_f_to_cie #(.DSIZE(DSIZE)) dut (
        .clock (clock),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [15:0] fx;
        logic [15:0] fy;
        logic [15:0] fz;
        logic [6:0]  l;
        logic [9:0]  a;
        logic [8:0]  b;
        logic        sat;
    } vec_t;

    vec_t vecs[8];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.in_valid = 1'b1;
        bus.fx       = v.fx;
        bus.fy       = v.fy;
        bus.fz       = v.fz;
    endtask

    // One isolated beat: accept, then expect out_valid on the 3rd cycle and the right fields.
    task automatic send_one(input vec_t v, input int idx);
        int n;
        bit seen;
        @(negedge clock);
        bus.out_ready = 1'b1;
        drive(v);
        #1;
        check($sformatf("v%0d_in_ready", idx), 32'(bus.in_ready), 32'd1);
        @(posedge clock);
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 10) begin
            @(negedge clock);
            bus.in_valid = 1'b0;
            n++;
            if (bus.out_valid) seen = 1'b1;
        end
        check($sformatf("v%0d_latency", idx), seen ? 32'(n) : 32'd0, 32'd3);
        check($sformatf("v%0d_L", idx), 32'(bus.CIE_L), 32'(v.l));
        check($sformatf("v%0d_A", idx), 32'(bus.CIE_A), 32'(v.a));
        check($sformatf("v%0d_B", idx), 32'(bus.CIE_B), 32'(v.b));
        check($sformatf("v%0d_sign_a", idx), 32'(bus.sign_a), 32'(v.a[9]));
        check($sformatf("v%0d_sign_b", idx), 32'(bus.sign_b), 32'(v.b[8]));
`ifdef LAB_SAT_FLAG_EN
        check($sformatf("v%0d_sat", idx), 32'(bus.sat), 32'(v.sat));
`endif
    endtask

    task automatic stall_test();
        int  nin;
        int  nout;
        int  extra;
        bit  have_held;
        logic [25:0] held;
        nin       = 0;
        nout      = 0;
        extra     = 0;
        have_held = 1'b0;
        held      = '0;
        for (int c = 0; c < 40 && nout < 6; c++) begin
            @(negedge clock);
            bus.out_ready = !(c >= 4 && c < 9);
            if (nin < 6) drive(vecs[nin]);
            else bus.in_valid = 1'b0;
            #1;
            if (bus.out_valid && !bus.out_ready) begin
                check($sformatf("stall_in_ready_c%0d", c), 32'(bus.in_ready), 32'd0);
                if (!have_held) begin
                    held      = {bus.CIE_L, bus.CIE_A, bus.CIE_B};
                    have_held = 1'b1;
                end else begin
                    check($sformatf("stall_hold_c%0d", c), 32'({bus.CIE_L, bus.CIE_A, bus.CIE_B}), 32'(held));
                end
            end
            if (bus.in_valid && bus.in_ready) nin++;
            if (bus.out_valid && bus.out_ready) begin
                check($sformatf("stream_%0d", nout), 32'({bus.CIE_L, bus.CIE_A, bus.CIE_B}),
                      32'({vecs[nout].l, vecs[nout].a, vecs[nout].b}));
                nout++;
            end
        end
        @(negedge clock);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clock);
            if (bus.out_valid) extra++;
        end
        check("stream_count", 32'(nout), 32'd6);
        check("stream_stall_seen", 32'(have_held), 32'd1);
        check("stream_no_dup", 32'(extra), 32'd0);
    endtask

    task automatic reset_test();
        bus.out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            drive(vecs[k]);
        end
        @(negedge clock);
        bus.in_valid = 1'b0;
        #1;
        check("rst_inflight_valid", 32'(bus.out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_fields", 32'({bus.CIE_L, bus.CIE_A, bus.CIE_B, bus.sign_a, bus.sign_b}), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clock);
        rst_n = 1'b1;
        #1;
        check("rst_no_replay", 32'(bus.out_valid), 32'd0);
        send_one(vecs[6], 100);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{16'h8000, 16'h8000, 16'h8000, 7'd42,  10'h000, 9'h000, 1'b0};
        vecs[1] = '{16'hC000, 16'h8000, 16'hC000, 7'd42,  10'h07D, 9'h1CE, 1'b0};
        vecs[2] = '{16'h0000, 16'hFFFF, 16'h0000, 7'd100, 10'h20C, 9'h0C8, 1'b0};
        vecs[3] = '{16'h2234, 16'h2234, 16'h2234, 7'd0,   10'h000, 9'h000, 1'b1};
        vecs[4] = '{16'h2235, 16'h2235, 16'h2235, 7'd0,   10'h000, 9'h000, 1'b0};
        vecs[5] = '{16'hFFFF, 16'h0000, 16'hFFFF, 7'd0,   10'h1F4, 9'h138, 1'b1};
        vecs[6] = '{16'h0000, 16'h4000, 16'h8000, 7'd13,  10'h383, 9'h1CE, 1'b0};
        vecs[7] = '{16'h7FFF, 16'h8000, 16'h8001, 7'd42,  10'h000, 9'h000, 1'b0};

        bus.in_valid  = 1'b0;
        bus.fx        = '0;
        bus.fy        = '0;
        bus.fz        = '0;
        bus.out_ready = 1'b1;
        rst_n         = 1'b0;

        repeat (2) @(negedge clock);
        check("reset_out_valid", 32'(bus.out_valid), 32'd0);
        check("reset_fields", 32'({bus.CIE_L, bus.CIE_A, bus.CIE_B}), 32'd0);
        check("reset_in_ready", 32'(bus.in_ready), 32'd1);
`ifdef LAB_SAT_FLAG_EN
        check("reset_sat", 32'(bus.sat), 32'd0);
`endif
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) send_one(vecs[i], i);

        stall_test();
        reset_test();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
